// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline control unit.
//   - stall vector encodings (bit 0 PC .. bit 5 WB, Stop = 1)
//   - trap-sequencer state codes
//   - stall-request bundle and the stall priority encoder
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned INST_ADDR_W = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [STALL_W-1:0]     stall_vec_t;

  localparam inst_addr_t ZERO_WORD = '0;

  // Each request freezes its own stage and everything upstream of it.
  localparam stall_vec_t STALL_NONE = {6{NO_STOP}};
  localparam stall_vec_t STALL_IF   = {{4{NO_STOP}}, {2{STOP}}};
  localparam stall_vec_t STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
  localparam stall_vec_t STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
  localparam stall_vec_t STALL_MEM  = {NO_STOP, {5{STOP}}};

  typedef enum logic [1:0] {
    CTRL_IDLE       = 2'd0,
    CTRL_TRAP_WAIT  = 2'd1,
    CTRL_TRAP_FLUSH = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  // Deepest requesting stage wins.
  function automatic stall_vec_t stall_prio(input stall_req_t req);
    if (req.mem)        return STALL_MEM;
    else if (req.ex)    return STALL_EX;
    else if (req.id)    return STALL_ID;
    else if (req.fetch) return STALL_IF;
    else                return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: core-side bundle of the pipeline control unit.
//   master: the pipeline stages (drive requests, consume stall/flush/redirect)
//   slave : pipe_ctrl
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       stallreq_if_i;
  logic       stallreq_id_i;
  logic       stallreq_ex_i;
  logic       stallreq_mem_i;
  logic       branch_redirect_i;
  inst_addr_t branch_target_i;
  logic       trap_i;
  inst_addr_t trap_vec_i;
  stall_vec_t stall_o;
  logic       flush_o;
  logic       redirect_o;
  inst_addr_t redirect_pc_o;
  logic       trap_busy_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output branch_redirect_i, branch_target_i, trap_i, trap_vec_i,
    input  stall_o, flush_o, redirect_o, redirect_pc_o, trap_busy_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  branch_redirect_i, branch_target_i, trap_i, trap_vec_i,
    output stall_o, flush_o, redirect_o, redirect_pc_o, trap_busy_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// stall_wdog: counts consecutive cycles with the PC frozen and raises a
// sticky timeout flag once the count reaches LIMIT.
//   clk_i, n_rst_i : clock, async active-low reset
//   stall_pc_i     : stall_o[0] of the pipeline
//   timeout_o      : sticky flag, cleared only by reset
module stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic stall_pc_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of the current stall run; any free cycle restarts it.
  always_comb begin
    cnt_d = '0;
    if (stall_pc_i == STOP) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (32'(cnt_d) >= LIMIT) timeout_o <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect control for the five-stage core.
//   clk_i, n_rst_i  : clock, async active-low reset
//   bus (slave)     : stall requests, branch redirect, trap in;
//                     stall_o, flush_o, redirect_o, redirect_pc_o, trap_busy_o out
//   stall_timeout_o : stall watchdog flag, only with PIPE_CTRL_WDOG_EN defined
// Optional feature macro: PIPE_CTRL_WDOG_EN (instantiates stall_wdog).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_WDOG_EN
  ,
  output logic       stall_timeout_o
`endif
);

  ctrl_state_e state_q, state_d;
  inst_addr_t  trap_pc_q;
  logic        trap_busy_q;
  stall_req_t  req_c;
  stall_vec_t  stall_c;
  logic        flush_c;
  logic        redirect_c;
  inst_addr_t  redirect_pc_c;

  assign req_c = '{mem:   bus.stallreq_mem_i,
                   ex:    bus.stallreq_ex_i,
                   id:    bus.stallreq_id_i,
                   fetch: bus.stallreq_if_i};

  // State register.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state_q <= CTRL_IDLE;
    else          state_q <= state_d;
  end

  // Trap target capture (first trap only) and registered busy flag.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      trap_pc_q   <= ZERO_WORD;
      trap_busy_q <= 1'b0;
    end else begin
      if (state_q == CTRL_IDLE && bus.trap_i) trap_pc_q <= bus.trap_vec_i;
      trap_busy_q <= (state_d != CTRL_IDLE);
    end
  end

  // Next state: wait out a pending data-bus transaction before flushing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CTRL_IDLE: begin
        if (bus.trap_i) state_d = bus.stallreq_mem_i ? CTRL_TRAP_WAIT : CTRL_TRAP_FLUSH;
      end
      CTRL_TRAP_WAIT: begin
        if (!bus.stallreq_mem_i) state_d = CTRL_TRAP_FLUSH;
      end
      CTRL_TRAP_FLUSH: state_d = CTRL_IDLE;
      default:         state_d = CTRL_IDLE;
    endcase
  end

  // Outputs: stall priority plus state overrides; branches only act in IDLE.
  always_comb begin
    stall_c       = stall_prio(req_c);
    flush_c       = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = ZERO_WORD;
    unique case (state_q)
      CTRL_IDLE: begin
        if (bus.branch_redirect_i) begin
          redirect_c    = 1'b1;
          redirect_pc_c = bus.branch_target_i;
        end
      end
      CTRL_TRAP_WAIT: stall_c = stall_c | STALL_EX;
      CTRL_TRAP_FLUSH: begin
        stall_c       = STALL_NONE;
        flush_c       = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = trap_pc_q;
      end
      default: ;
    endcase
    // Outputs read all-zero while reset is held, including the request-driven stall.
    if (!n_rst_i) begin
      stall_c       = STALL_NONE;
      flush_c       = 1'b0;
      redirect_c    = 1'b0;
      redirect_pc_c = ZERO_WORD;
    end
  end

  assign bus.stall_o       = stall_c;
  assign bus.flush_o       = flush_c;
  assign bus.redirect_o    = redirect_c;
  assign bus.redirect_pc_o = redirect_pc_c;
  assign bus.trap_busy_o   = trap_busy_q;

`ifdef PIPE_CTRL_WDOG_EN
  stall_wdog #(.LIMIT(WDOG_LIMIT)) u_stall_wdog (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .stall_pc_i (stall_c[0]),
    .timeout_o  (stall_timeout_o)
  );
`else
  logic wdog_limit_unused;
  assign wdog_limit_unused = ^WDOG_LIMIT;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl. The driver applies one input
// vector per cycle just after the rising edge and queues the hand-computed
// outputs for that cycle; the monitor pops and checks on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned WDOG_LIMIT = 8;

  logic clk_i = 1'b0;
  logic n_rst_i;
  always #5 clk_i = ~clk_i;

  pipe_ctrl_if bus_if();
`ifdef PIPE_CTRL_WDOG_EN
  logic stall_timeout_o;
`endif

  pipe_ctrl #(.WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .bus     (bus_if)
`ifdef PIPE_CTRL_WDOG_EN
    ,
    .stall_timeout_o (stall_timeout_o)
`endif
  );

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic        redir;
    logic [31:0] pc;
    logic        busy;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  logic act_tmo;

  // req = {mem, ex, id, if}
  task automatic apply(input string nm, input logic rst, input logic [3:0] req,
                       input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tv,
                       input logic [5:0] es, input logic ef, input logic er,
                       input logic [31:0] ep, input logic eb, input logic et);
    exp_t x;
    @(posedge clk_i);
    #1;
    n_rst_i                  = rst;
    bus_if.stallreq_mem_i    = req[3];
    bus_if.stallreq_ex_i     = req[2];
    bus_if.stallreq_id_i     = req[1];
    bus_if.stallreq_if_i     = req[0];
    bus_if.branch_redirect_i = br;
    bus_if.branch_target_i   = bt;
    bus_if.trap_i            = tr;
    bus_if.trap_vec_i        = tv;
    x.name = nm; x.stall = es; x.flush = ef; x.redir = er;
    x.pc = ep; x.busy = eb; x.tmo = et;
    exp_q.push_back(x);
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
`ifdef PIPE_CTRL_WDOG_EN
        act_tmo = stall_timeout_o;
`else
        act_tmo = 1'b0;
`endif
        vectors++;
        if (bus_if.stall_o !== e.stall || bus_if.flush_o !== e.flush ||
            bus_if.redirect_o !== e.redir || bus_if.redirect_pc_o !== e.pc ||
            bus_if.trap_busy_o !== e.busy || act_tmo !== e.tmo) begin
          miscompares++;
          $display("FAIL %s: got stall=%b flush=%b redir=%b pc=%h busy=%b tmo=%b, want stall=%b flush=%b redir=%b pc=%h busy=%b tmo=%b",
                   e.name, bus_if.stall_o, bus_if.flush_o, bus_if.redirect_o,
                   bus_if.redirect_pc_o, bus_if.trap_busy_o, act_tmo,
                   e.stall, e.flush, e.redir, e.pc, e.busy, e.tmo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not complete within time limit");
    $fatal(1, "simulation time limit expired");
  end

  initial begin
    n_rst_i                  = 1'b0;
    bus_if.stallreq_if_i     = 1'b0;
    bus_if.stallreq_id_i     = 1'b0;
    bus_if.stallreq_ex_i     = 1'b0;
    bus_if.stallreq_mem_i    = 1'b0;
    bus_if.branch_redirect_i = 1'b0;
    bus_if.branch_target_i   = '0;
    bus_if.trap_i            = 1'b0;
    bus_if.trap_vec_i        = '0;

    //     name            rst req      br  target        tr  vector        stall      fl er pc            bsy tmo
    apply("reset",         0, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("idle",          1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("if_only",       1, 4'b0001, 0, 32'h0,        0, 32'h0,        6'b000011, 0, 0, 32'h0,        0, 0);
    apply("id_only",       1, 4'b0010, 0, 32'h0,        0, 32'h0,        6'b000111, 0, 0, 32'h0,        0, 0);
    apply("ex_id",         1, 4'b0110, 0, 32'h0,        0, 32'h0,        6'b001111, 0, 0, 32'h0,        0, 0);
    apply("mem_all",       1, 4'b1111, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 0, 32'h0,        0, 0);
    apply("branch_idle",   1, 4'b0000, 1, 32'h40,       0, 32'h0,        6'b000000, 0, 1, 32'h40,       0, 0);
    apply("trap_nostall",  1, 4'b0000, 0, 32'h0,        1, 32'h80000100, 6'b000000, 0, 0, 32'h0,        0, 0);
    apply("trap_flush",    1, 4'b0001, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 1, 32'h80000100, 1, 0);
    apply("after_flush",   1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("trap_mem",      1, 4'b1000, 0, 32'h0,        1, 32'h80000200, 6'b011111, 0, 0, 32'h0,        0, 0);
    apply("wait1",         1, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 0, 32'h0,        1, 0);
    apply("wait2_br_trap", 1, 4'b1000, 1, 32'h40,       1, 32'hdeadbeef, 6'b011111, 0, 0, 32'h0,        1, 0);
    apply("wait3",         1, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 0, 32'h0,        1, 0);
    apply("wait_release",  1, 4'b0010, 0, 32'h0,        0, 32'h0,        6'b001111, 0, 0, 32'h0,        1, 0);
    apply("trap_flush2",   1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 1, 32'h80000200, 1, 0);
    apply("idle2",         1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("trap_and_br",   1, 4'b0000, 1, 32'h44,       1, 32'h300,      6'b000000, 0, 1, 32'h44,       0, 0);
    apply("flush_over_br", 1, 4'b0000, 1, 32'h48,       0, 32'h0,        6'b000000, 1, 1, 32'h300,      1, 0);
    apply("idle3",         1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("trap_mem2",     1, 4'b1000, 0, 32'h0,        1, 32'h400,      6'b011111, 0, 0, 32'h0,        0, 0);
    apply("wait_r",        1, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 0, 32'h0,        1, 0);
    apply("rst_mid_trap",  0, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("rst_release",   1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);
    apply("no_flush",      1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 0);

`ifdef PIPE_CTRL_WDOG_EN
    // Count reaches WDOG_LIMIT at the end of the 8th stalled cycle.
    for (int i = 0; i < 9; i++) begin
      apply($sformatf("wdog%0d", i), 1, 4'b1000, 0, 32'h0, 0, 32'h0,
            6'b011111, 0, 0, 32'h0, 0, (i >= 8) ? 1'b1 : 1'b0);
    end
    apply("wdog_cleared",  1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 1);
    apply("wdog_sticky",   1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 0, 32'h0,        0, 1);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
